// File: rtl/dbus_mem_responder_pkg.sv
// rtl/dbus_mem_responder_pkg.sv - dbus request/response types, size encodings and alignment helper
package dbus_mem_responder_pkg;

  localparam int DBUS_WORD_BYTES = 8;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  // Only the low three address bits matter; unknown size encodings are treated as misaligned.
  function automatic logic dbus_misaligned(input logic [2:0] addr, input logic [2:0] size);
    case (size)
      MSIZE1:  return 1'b0;
      MSIZE2:  return addr[0];
      MSIZE4:  return |addr[1:0];
      MSIZE8:  return |addr[2:0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dbus_mem_array.sv
// rtl/dbus_mem_array.sv - 1R1W 64-bit word array with byte-enable write and combinational read
module dbus_mem_array
  import dbus_mem_responder_pkg::*;
#(
  parameter int WORDS = 4096,
  localparam int AW = $clog2(WORDS)
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [AW-1:0]                waddr,
  input  logic [DBUS_WORD_BYTES-1:0]   strobe,
  input  logic [63:0]                  wdata,
  input  logic [AW-1:0]                raddr,
  output logic [63:0]                  rdata
);

  logic [63:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DBUS_WORD_BYTES; i++) begin
        if (strobe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dbus_mem_responder.sv
// rtl/dbus_mem_responder.sv - dbus responder backed by an internal word memory with fixed latency
module dbus_mem_responder
  import dbus_mem_responder_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'd8;
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [63:0] addr_q;
  logic [2:0]  size_q;
  logic [7:0]  strobe_q;
  logic [63:0] data_q;

  logic [63:0] cur_addr;
  logic [2:0]  cur_size;
  logic [7:0]  cur_strobe;
  logic [63:0] cur_data;
  logic [63:0] off;
  logic [AW-1:0] idx;
  logic        bad;
  logic        we;
  logic [63:0] rd_word;

  // In IDLE the live request is decoded so a zero-latency response can be registered immediately.
  always_comb begin
    cur_addr   = (state == IDLE) ? dreq.addr   : addr_q;
    cur_size   = (state == IDLE) ? dreq.size   : size_q;
    cur_strobe = (state == IDLE) ? dreq.strobe : strobe_q;
    cur_data   = (state == IDLE) ? dreq.data   : data_q;
    off        = cur_addr - BASE_ADDR;
    idx        = off[AW+2:3];
    bad        = (cur_addr < BASE_ADDR) || (off >= MEM_BYTES) ||
                 dbus_misaligned(cur_addr[2:0], cur_size);
    we         = (state == RESP) && (|cur_strobe) && !bad;
  end

  dbus_mem_array #(.WORDS(MEM_WORDS)) u_array (
    .clk    (clk),
    .we     (we),
    .waddr  (idx),
    .strobe (cur_strobe),
    .wdata  (cur_data),
    .raddr  (idx),
    .rdata  (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dresp    <= '0;
      err      <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      data_q   <= '0;
    end else begin
      dresp <= '0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (dreq.valid) begin
            addr_q   <= dreq.addr;
            size_q   <= dreq.size;
            strobe_q <= dreq.strobe;
            data_q   <= dreq.data;
            if (LATENCY > 0) begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end else begin
              state         <= RESP;
              dresp.addr_ok <= 1'b1;
              dresp.data_ok <= 1'b1;
              dresp.data    <= bad ? 64'd0 : rd_word;
              err           <= bad;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state         <= RESP;
            dresp.addr_ok <= 1'b1;
            dresp.data_ok <= 1'b1;
            dresp.data    <= bad ? 64'd0 : rd_word;
            err           <= bad;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
